// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Signal bundle between the fetch/data requesters, the
//                mem_bus_arbiter and the single-ported memory bus.
//                master = arbiter side, slave = requester/bus environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    // data requester
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [3:0]        d_sel_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;
    // external memory bus
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_sel_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;
    // pipeline control / status
    logic              stall_req_if_o;
    logic              stall_req_mem_o;
    logic              err_o;

    modport master (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o,
        input  d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
        output d_rdata_o, d_ack_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i,
        output stall_req_if_o, stall_req_mem_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o,
        output d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
        input  d_rdata_o, d_ack_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i,
        input  stall_req_if_o, stall_req_mem_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-requester (fetch / data) arbiter onto one req/ack memory
//                bus. One transaction per grant, alternating priority when
//                both requesters are pending, data wins ties by default.
//                Optional watchdog: define MEM_BUS_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                Rst_n,
    mem_bus_arbiter_if.master   mbi
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    state_t            r_state,     w_state_nxt;
    grant_t            r_last,      w_last_nxt;
    logic              r_bus_req,   w_bus_req_nxt;
    logic              r_bus_we,    w_bus_we_nxt;
    logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
    logic [3:0]        r_bus_sel,   w_bus_sel_nxt;
    logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
    logic              r_if_ack,    w_if_ack_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic              r_d_ack,     w_d_ack_nxt;
    logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;

    logic w_grant_d;
    logic w_grant_if;
    logic w_timeout;

    // Data wins a tie unless it won the previous grant, so neither side starves
    assign w_grant_d  = mbi.d_req_i & (~mbi.if_req_i | (r_last == GRANT_FETCH));
    assign w_grant_if = mbi.if_req_i & ~w_grant_d;

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_last      <= GRANT_FETCH;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= 4'h0;
            r_bus_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_ack     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, hold the bus in WAIT until ack or timeout
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_wdata_nxt = r_bus_wdata;
        w_if_ack_nxt    = 1'b0;
        w_if_rdata_nxt  = '0;
        w_d_ack_nxt     = 1'b0;
        w_d_rdata_nxt   = '0;

        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt     = D_WAIT;
                    w_last_nxt      = GRANT_DATA;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = mbi.d_we_i;
                    w_bus_addr_nxt  = mbi.d_addr_i;
                    w_bus_sel_nxt   = mbi.d_sel_i;
                    w_bus_wdata_nxt = mbi.d_wdata_i;
                end else if (w_grant_if) begin
                    w_state_nxt     = I_WAIT;
                    w_last_nxt      = GRANT_FETCH;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = mbi.if_addr_i;
                    w_bus_sel_nxt   = 4'hF;
                    w_bus_wdata_nxt = '0;
                end
            end
            D_WAIT: begin
                if (mbi.bus_ack_i) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_d_ack_nxt   = 1'b1;
                    w_d_rdata_nxt = r_bus_we ? '0 : mbi.bus_rdata_i;
                end else if (w_timeout) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_d_ack_nxt   = 1'b1;
                end
            end
            I_WAIT: begin
                if (mbi.bus_ack_i) begin
                    w_state_nxt    = IDLE;
                    w_bus_req_nxt  = 1'b0;
                    w_if_ack_nxt   = 1'b1;
                    w_if_rdata_nxt = mbi.bus_rdata_i;
                end else if (w_timeout) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_if_ack_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    // Unacked WAIT cycles; held at zero in IDLE so each wait starts fresh
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_wait_cnt <= '0;
        end else if (!mbi.bus_ack_i) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // A real ack on the limit cycle takes precedence over the timeout
    assign w_timeout = (r_state != IDLE) && !mbi.bus_ack_i &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign mbi.err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign mbi.err_o = 1'b0;
`endif

    assign mbi.bus_req_o       = r_bus_req;
    assign mbi.bus_we_o        = r_bus_we;
    assign mbi.bus_addr_o      = r_bus_addr;
    assign mbi.bus_sel_o       = r_bus_sel;
    assign mbi.bus_wdata_o     = r_bus_wdata;
    assign mbi.if_ack_o        = r_if_ack;
    assign mbi.if_rdata_o      = r_if_rdata;
    assign mbi.d_ack_o         = r_d_ack;
    assign mbi.d_rdata_o       = r_d_rdata;
    assign mbi.stall_req_if_o  = mbi.if_req_i & ~r_if_ack;
    assign mbi.stall_req_mem_o = mbi.d_req_i & ~r_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mbi ();

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .Rst_n (rst_n),
        .mbi   (mbi)
    );

    // ---------------- reference model (transaction level) ----------------
    int          m_owner;      // 0 = bus free, 1 = data transaction, 2 = fetch transaction
    bit          m_last_data;  // previous grant went to the data port
    int          m_waited;     // unacked cycles spent on the current transaction
    logic        m_bus_req, m_bus_we, m_if_ack, m_d_ack, m_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]  m_sel;

    task automatic model_reset();
        m_owner = 0; m_last_data = 1'b0; m_waited = 0;
        m_bus_req = 1'b0; m_bus_we = 1'b0; m_if_ack = 1'b0; m_d_ack = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_sel = '0;
    endtask

    task automatic model_edge();
        int pick;
        m_if_ack = 1'b0; m_d_ack = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
        if (m_owner == 0) begin
            if (mbi.d_req_i && mbi.if_req_i) pick = m_last_data ? 2 : 1;
            else if (mbi.d_req_i)            pick = 1;
            else if (mbi.if_req_i)           pick = 2;
            else                             pick = 0;
            if (pick == 1) begin
                m_owner = 1; m_last_data = 1'b1; m_waited = 0; m_bus_req = 1'b1;
                m_bus_we = mbi.d_we_i; m_addr = mbi.d_addr_i; m_sel = mbi.d_sel_i; m_wdata = mbi.d_wdata_i;
            end else if (pick == 2) begin
                m_owner = 2; m_last_data = 1'b0; m_waited = 0; m_bus_req = 1'b1;
                m_bus_we = 1'b0; m_addr = mbi.if_addr_i; m_sel = 4'hF; m_wdata = '0;
            end
        end else if (mbi.bus_ack_i) begin
            if (m_owner == 1) begin m_d_ack = 1'b1; m_d_rdata = m_bus_we ? 32'h0 : mbi.bus_rdata_i; end
            else begin m_if_ack = 1'b1; m_if_rdata = mbi.bus_rdata_i; end
            m_owner = 0; m_bus_req = 1'b0;
        end else begin
            m_waited++;
            if (TMO_EN && m_waited == TMO) begin
                if (m_owner == 1) m_d_ack = 1'b1; else m_if_ack = 1'b1;
                m_owner = 0; m_bus_req = 1'b0; m_err = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_idle();
        mbi.if_req_i = 1'b0; mbi.if_addr_i = '0;
        mbi.d_req_i = 1'b0; mbi.d_we_i = 1'b0; mbi.d_addr_i = '0; mbi.d_sel_i = '0; mbi.d_wdata_i = '0;
        mbi.bus_ack_i = 1'b0; mbi.bus_rdata_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        checks++;
        if ({mbi.bus_req_o, mbi.if_ack_o, mbi.d_ack_o, mbi.err_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got=%b want=0000", {mbi.bus_req_o, mbi.if_ack_o, mbi.d_ack_o, mbi.err_o});
        end
        checks++;
        if ({mbi.bus_addr_o, mbi.if_rdata_o, mbi.d_rdata_o} !== 96'h0) begin
            errors++; $display("FAIL reset_data got=%h want=0", {mbi.bus_addr_o, mbi.if_rdata_o, mbi.d_rdata_o});
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        drive_idle();
        mbi.if_req_i = 1'b1; mbi.if_addr_i = 32'h100;
        #1;
        checks++;
        if (mbi.stall_req_if_o !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_early got=%b want=1", mbi.stall_req_if_o);
        end
        step();
        checks++;
        if ({mbi.bus_req_o, mbi.bus_we_o, mbi.bus_addr_o, mbi.bus_sel_o, mbi.bus_wdata_o} !== {1'b1, 1'b0, 32'h100, 4'hF, 32'h0}) begin
            errors++; $display("FAIL fetch_bus got=%h want=%h", {mbi.bus_req_o, mbi.bus_we_o, mbi.bus_addr_o, mbi.bus_sel_o, mbi.bus_wdata_o}, {1'b1, 1'b0, 32'h100, 4'hF, 32'h0});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({mbi.if_ack_o, mbi.stall_req_if_o, mbi.bus_req_o} !== 3'b011) begin
                errors++; $display("FAIL fetch_wait%0d got=%b want=011", i, {mbi.if_ack_o, mbi.stall_req_if_o, mbi.bus_req_o});
            end
        end
        mbi.bus_ack_i = 1'b1; mbi.bus_rdata_i = 32'h3C01_0001;
        step();
        checks++;
        if ({mbi.if_ack_o, mbi.stall_req_if_o, mbi.bus_req_o, mbi.d_ack_o, mbi.if_rdata_o} !== {4'b1000, 32'h3C01_0001}) begin
            errors++; $display("FAIL fetch_ack got=%h want=%h", {mbi.if_ack_o, mbi.stall_req_if_o, mbi.bus_req_o, mbi.d_ack_o, mbi.if_rdata_o}, {4'b1000, 32'h3C01_0001});
        end
        mbi.if_req_i = 1'b0; mbi.bus_ack_i = 1'b0;
        step();
        checks++;
        if ({mbi.if_ack_o, mbi.if_rdata_o} !== 33'h0) begin
            errors++; $display("FAIL fetch_after got=%h want=0", {mbi.if_ack_o, mbi.if_rdata_o});
        end
    endtask

    task automatic test_store();
        drive_idle();
        mbi.d_req_i = 1'b1; mbi.d_we_i = 1'b1; mbi.d_addr_i = 32'h40; mbi.d_sel_i = 4'b0011;
        mbi.d_wdata_i = 32'hDEAD_BEEF; mbi.bus_ack_i = 1'b1; mbi.bus_rdata_i = 32'h1234_5678;
        step();
        checks++;
        if ({mbi.bus_req_o, mbi.bus_we_o, mbi.bus_addr_o, mbi.bus_sel_o, mbi.bus_wdata_o, mbi.d_ack_o} !== {2'b11, 32'h40, 4'b0011, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL store_bus got=%h want=%h", {mbi.bus_req_o, mbi.bus_we_o, mbi.bus_addr_o, mbi.bus_sel_o, mbi.bus_wdata_o, mbi.d_ack_o}, {2'b11, 32'h40, 4'b0011, 32'hDEAD_BEEF, 1'b0});
        end
        step();
        checks++;
        if ({mbi.d_ack_o, mbi.bus_req_o, mbi.stall_req_mem_o, mbi.d_rdata_o} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL store_ack got=%h want=%h", {mbi.d_ack_o, mbi.bus_req_o, mbi.stall_req_mem_o, mbi.d_rdata_o}, {3'b100, 32'h0});
        end
        drive_idle();
        step();
        checks++;
        if (mbi.d_ack_o !== 1'b0) begin
            errors++; $display("FAIL store_after got=%b want=0", mbi.d_ack_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        logic        exp_d;
        apply_reset();
        mbi.d_req_i = 1'b1; mbi.d_we_i = 1'b0; mbi.d_addr_i = 32'h200; mbi.d_sel_i = 4'hF;
        mbi.if_req_i = 1'b1; mbi.if_addr_i = 32'h300; mbi.bus_ack_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2 == 0);
            exp_addr = exp_d ? 32'h200 : 32'h300;
            mbi.bus_rdata_i = 32'hA5A5_0000 + 32'(t);
            step();
            checks++;
            if ({mbi.bus_req_o, mbi.bus_addr_o, mbi.if_ack_o, mbi.d_ack_o} !== {1'b1, exp_addr, 2'b00}) begin
                errors++; $display("FAIL b2b_grant%0d got=%h want=%h", t, {mbi.bus_req_o, mbi.bus_addr_o, mbi.if_ack_o, mbi.d_ack_o}, {1'b1, exp_addr, 2'b00});
            end
            step();
            checks++;
            if ({mbi.bus_req_o, mbi.d_ack_o, mbi.if_ack_o, (exp_d ? mbi.d_rdata_o : mbi.if_rdata_o)} !== {1'b0, exp_d, ~exp_d, 32'hA5A5_0000 + 32'(t)}) begin
                errors++; $display("FAIL b2b_ack%0d got=%h want=%h", t, {mbi.bus_req_o, mbi.d_ack_o, mbi.if_ack_o, (exp_d ? mbi.d_rdata_o : mbi.if_rdata_o)}, {1'b0, exp_d, ~exp_d, 32'hA5A5_0000 + 32'(t)});
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mbi.d_req_i = 1'b1; mbi.d_we_i = 1'b0; mbi.d_addr_i = 32'h80; mbi.d_sel_i = 4'hF;
        step();
        step();
        checks++;
        if (mbi.bus_req_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_wait got=%b want=1", mbi.bus_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mbi.bus_req_o, mbi.d_ack_o} !== 2'b00) begin
            errors++; $display("FAIL rstmid_async got=%b want=00", {mbi.bus_req_o, mbi.d_ack_o});
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({mbi.bus_req_o, mbi.bus_addr_o} !== {1'b1, 32'h80}) begin
            errors++; $display("FAIL rstmid_reissue got=%h want=%h", {mbi.bus_req_o, mbi.bus_addr_o}, {1'b1, 32'h80});
        end
        mbi.bus_ack_i = 1'b1; mbi.bus_rdata_i = 32'h0BAD_F00D;
        step();
        checks++;
        if ({mbi.d_ack_o, mbi.d_rdata_o} !== {1'b1, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL rstmid_ack got=%h want=%h", {mbi.d_ack_o, mbi.d_rdata_o}, {1'b1, 32'h0BAD_F00D});
        end
        drive_idle();
        step();
        checks++;
        if ({mbi.d_ack_o, mbi.d_rdata_o} !== 33'h0) begin
            errors++; $display("FAIL rstmid_after got=%h want=0", {mbi.d_ack_o, mbi.d_rdata_o});
        end
    endtask

    task automatic test_timeout();
        int early_acks;
        apply_reset();
        mbi.d_req_i = 1'b1; mbi.d_we_i = 1'b0; mbi.d_addr_i = 32'h44; mbi.d_sel_i = 4'hF;
        mbi.bus_rdata_i = 32'hFFFF_FFFF;
        step();
        early_acks = 0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            if (mbi.d_ack_o !== 1'b0 || mbi.bus_req_o !== 1'b1) early_acks++;
        end
        checks++;
        if (early_acks != 0) begin
            errors++; $display("FAIL tmo_early got=%0d want=0", early_acks);
        end
        step();
        checks++;
        if ({mbi.d_ack_o, mbi.bus_req_o, mbi.err_o, mbi.d_rdata_o} !== {3'b101, 32'h0}) begin
            errors++; $display("FAIL tmo_fire got=%h want=%h", {mbi.d_ack_o, mbi.bus_req_o, mbi.err_o, mbi.d_rdata_o}, {3'b101, 32'h0});
        end
        drive_idle();
        step();
        step();
        checks++;
        if ({mbi.err_o, mbi.d_ack_o} !== 2'b10) begin
            errors++; $display("FAIL tmo_sticky got=%b want=10", {mbi.err_o, mbi.d_ack_o});
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            if (mbi.d_ack_o !== 1'b0 || mbi.bus_req_o !== 1'b1 || mbi.err_o !== 1'b0) early_acks++;
        end
        checks++;
        if (early_acks != 0) begin
            errors++; $display("FAIL notmo_wait got=%0d want=0", early_acks);
        end
`endif
        apply_reset();
        checks++;
        if (mbi.err_o !== 1'b0) begin
            errors++; $display("FAIL tmo_reset_err got=%b want=0", mbi.err_o);
        end
    endtask

    task automatic test_idle_ack();
        apply_reset();
        mbi.bus_ack_i = 1'b1; mbi.bus_rdata_i = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({mbi.bus_req_o, mbi.if_ack_o, mbi.d_ack_o, mbi.if_rdata_o, mbi.d_rdata_o} !== 67'h0) begin
                errors++; $display("FAIL idle_ack%0d got=%h want=0", i, {mbi.bus_req_o, mbi.if_ack_o, mbi.d_ack_o, mbi.if_rdata_o, mbi.d_rdata_o});
            end
        end
        mbi.bus_ack_i = 1'b0; mbi.if_req_i = 1'b1; mbi.if_addr_i = 32'h500;
        step();
        checks++;
        if ({mbi.bus_req_o, mbi.bus_addr_o} !== {1'b1, 32'h500}) begin
            errors++; $display("FAIL idle_then_grant got=%h want=%h", {mbi.bus_req_o, mbi.bus_addr_o}, {1'b1, 32'h500});
        end
        mbi.bus_ack_i = 1'b1;
        step();
        drive_idle();
        step();
    endtask

    task automatic test_random();
        logic [138:0] act, exp;
        apply_reset();
        model_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            model_edge();
            step();
            exp = {m_bus_req, m_bus_we, m_addr, m_sel, m_wdata, m_if_ack, m_if_rdata, m_d_ack, m_d_rdata,
                   m_err, mbi.if_req_i & ~m_if_ack, mbi.d_req_i & ~m_d_ack};
            act = {mbi.bus_req_o, mbi.bus_we_o, mbi.bus_addr_o, mbi.bus_sel_o, mbi.bus_wdata_o,
                   mbi.if_ack_o, mbi.if_rdata_o, mbi.d_ack_o, mbi.d_rdata_o,
                   mbi.err_o, mbi.stall_req_if_o, mbi.stall_req_mem_o};
            checks++;
            if (act !== exp) begin
                errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, act, exp);
            end
            // requesters: raise sometimes, hold while waiting (rarely abandon), maybe re-issue after ack
            if (!mbi.d_req_i)  mbi.d_req_i = ($urandom_range(0, 9) < 4);
            else if (m_d_ack)  mbi.d_req_i = ($urandom_range(0, 1) == 1);
            else               mbi.d_req_i = ($urandom_range(0, 19) != 0);
            if (!mbi.if_req_i) mbi.if_req_i = ($urandom_range(0, 9) < 4);
            else if (m_if_ack) mbi.if_req_i = ($urandom_range(0, 1) == 1);
            else               mbi.if_req_i = ($urandom_range(0, 19) != 0);
            mbi.d_we_i      = ($urandom_range(0, 1) == 1);
            mbi.d_addr_i    = $urandom;
            mbi.d_sel_i     = 4'($urandom);
            mbi.d_wdata_i   = $urandom;
            mbi.if_addr_i   = $urandom;
            mbi.bus_ack_i   = ($urandom_range(0, 9) < 4);
            mbi.bus_rdata_i = $urandom;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_idle_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between two requesters: the instruction-fetch port (pc/if stage) and the data port (mem stage load/store).
- Sequences each access as a multi-cycle req/ack transaction and returns read data to the winning requester.
- Raises stall requests toward ctrl while a requester is waiting.
- Sits between the openmips core's rom/ram ports and a single-ported SRAM/bus wrapper.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width of requesters and bus.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetch read data; valid only in the if_ack_o cycle.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- d_req_i  in  1  data request (ram_ce); held until d_ack_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  ADDR_W  data address.
- d_sel_i  in  4  byte enables.
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data; valid only in the d_ack_o cycle.
- d_ack_o  out  1  one-cycle completion pulse for data.
- bus_req_o  out  1  bus transaction active.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  bus address.
- bus_sel_o  out  4  bus byte enables.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data; sampled with bus_ack_i.
- bus_ack_i  in  1  bus completion; may be high in the same cycle bus_req_o first rises.
- stall_req_if_o  out  1  = if_req_i & ~if_ack_o (combinational).
- stall_req_mem_o  out  1  = d_req_i & ~d_ack_o (combinational).
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset:
  - All registered outputs go to 0 asynchronously when Rst_n = 0.
  - State goes to IDLE and last_grant goes to FETCH.
  - An in-flight transaction is dropped; bus_req_o falls immediately.
- FSM states: IDLE, D_WAIT, I_WAIT.
- IDLE arbitration, evaluated each rising edge:
  - Both requests pending: grant DATA unless last_grant = DATA, in which case grant FETCH. This alternates the requesters and prevents starvation.
  - Only one request pending: grant it.
  - No request pending: remain in IDLE.
- On grant:
  - Register the winner's addr/we/sel/wdata onto the bus_* outputs and set bus_req_o = 1 from the next cycle.
  - Update last_grant.
  - Fetch grants always drive bus_we_o = 0, bus_sel_o = 4'hF, bus_wdata_o = 0.
- D_WAIT / I_WAIT:
  - Bus outputs are held stable.
  - On the first edge with bus_ack_i = 1: bus_req_o goes to 0; the winner's ack_o pulses 1 for exactly one cycle; its rdata_o takes bus_rdata_i (0 for writes); state returns to IDLE.
- Minimum latency: request sampled at edge N, ack_o high after edge N+1 (bus acks in its first cycle).
- One transaction per grant; no pipelining.
- A request still high in IDLE after its ack is treated as a new transaction.
- bus_ack_i is ignored in IDLE.
- rdata_o returns to 0 the cycle after the ack pulse.
- The non-granted requester sees ack_o = 0 and rdata_o = 0.
- A request dropped while waiting does not abort the bus transaction; the ack pulse is still issued.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to a WAIT state and increments each WAIT cycle without bus_ack_i.
  - When the counter reaches TIMEOUT_CYCLES: bus_req_o = 0; the winner gets an ack_o pulse with rdata_o = 0; err_o is set to 1 and stays high until reset; state returns to IDLE.
  - If bus_ack_i arrives in the same cycle as the limit, it completes normally and err_o is not set.
- Without the macro: WAIT states wait indefinitely; err_o is tied to 0; no counter logic is built.

Test Plan:
- Fetch only: if_req_i = 1, if_addr_i = 0x100, bus acks 3 cycles after bus_req_o with 0x3C010001 -> bus_addr_o = 0x100; if_ack_o one-cycle pulse with if_rdata_o = 0x3C010001; stall_req_if_o high until the ack cycle.
- Store: d_req_i = 1, d_we_i = 1, d_addr_i = 0x40, d_sel_i = 4'b0011, d_wdata_i = 0xDEADBEEF, immediate ack -> bus_we_o = 1, bus_sel_o = 4'b0011; d_ack_o after 2 edges; d_rdata_o = 0.
- Simultaneous requests twice in a row, both held -> grant order DATA, FETCH, DATA, FETCH; no ack overlap; bus_req_o low for one cycle between transactions.
- Reset mid-operation: assert Rst_n = 0 in D_WAIT -> bus_req_o and d_ack_o = 0 without a clock edge; after release, state is IDLE and the held d_req_i re-issues.
- Timeout (macro on, TIMEOUT_CYCLES = 4): bus never acks -> after 4 WAIT cycles d_ack_o pulses, d_rdata_o = 0, err_o = 1 and stays 1. With the macro off, no ack ever occurs and err_o = 0.
- Ack in IDLE: bus_ack_i pulsed with no request pending -> no ack_o and no state change.
